// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared line-interface constants and FSM encoding for the main-memory responder
package mm_pkg;

    localparam int LINE_BITS     = 256;
    localparam int LINE_OFF_BITS = 5;
    localparam int MM_ADDR_BITS  = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RBUSY = 2'd1;
    localparam logic [1:0] ST_WBUSY = 2'd2;

endpackage

// File: rtl/mm_store.sv
// rtl/mm_store.sv - line-wide backing store with one sync write port and one registered read port
module mm_store
    import mm_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [LINE_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [LINE_BITS-1:0] rdata
);

    // Array is deliberately not reset: contents survive a reset of the responder.
    logic [LINE_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds the last fill until the next read accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mm_model.sv
// rtl/mm_model.sv - main-memory responder FSM for the L1 line port; MM_PROTO_CHK_EN enables the sticky protocol checker
module mm_model
    import mm_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [MM_ADDR_BITS-1:0] mm_a,
    input  logic                    mm_read,
    input  logic                    mm_write,
    input  logic [LINE_BITS-1:0]    mm_wd,
    output logic [LINE_BITS-1:0]    mm_rd,
    output logic                    mm_valid,
    output logic                    mm_busy,
    output logic                    mm_err
);

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    logic [1:0]           state;
    logic [7:0]           cnt;
    logic [ADDR_BITS-1:0] req_idx;
    logic [ADDR_BITS-1:0] wr_idx;
    logic [LINE_BITS-1:0] wr_data;
    logic                 idle;
    logic                 accept_wr;
    logic                 accept_rd;
    logic                 store_we;
    logic                 unused_addr_bits;

    // Upper address bits alias onto the same line; offset bits select within a line.
    assign req_idx          = mm_a[ADDR_BITS+LINE_OFF_BITS-1:LINE_OFF_BITS];
    assign unused_addr_bits = ^{mm_a[MM_ADDR_BITS-1:ADDR_BITS+LINE_OFF_BITS], mm_a[LINE_OFF_BITS-1:0]};

    assign idle      = (state == ST_IDLE);
    assign accept_wr = idle && mm_write;
    assign accept_rd = idle && mm_read && !mm_write;
    assign store_we  = (state == ST_WBUSY) && (cnt == 8'd0);

    assign mm_busy  = !idle;
    assign mm_valid = (state == ST_RBUSY) && (cnt == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            wr_idx  <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_wr) begin
                        state   <= ST_WBUSY;
                        cnt     <= CNT_INIT;
                        wr_idx  <= req_idx;
                        wr_data <= mm_wd;
                    end else if (accept_rd) begin
                        state <= ST_RBUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_RBUSY, ST_WBUSY: begin
                    if (cnt == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    mm_store #(
        .ADDR_BITS(ADDR_BITS)
    ) mm_store0 (
        .clk   (clk),
        .reset (reset),
        .we    (store_we),
        .waddr (wr_idx),
        .wdata (wr_data),
        .re    (accept_rd),
        .raddr (req_idx),
        .rdata (mm_rd)
    );

`ifdef MM_PROTO_CHK_EN
    // Flags a read/write collision in IDLE or any request presented while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mm_err <= 1'b0;
        end else if ((idle && mm_read && mm_write) || (!idle && (mm_read || mm_write))) begin
            mm_err <= 1'b1;
        end
    end
`else
    assign mm_err = 1'b0;
`endif

endmodule

// File: tb/tb_mm_model.sv
// tb/tb_mm_model.sv - randomized and directed self-checking bench for mm_model against a transaction-level model
module tb_mm_model;

    localparam int LAT = 4;
`ifdef MM_PROTO_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  a = '0;
    logic         rd_req = 1'b0;
    logic         wr_req = 1'b0;
    logic [255:0] wd = '0;
    logic [255:0] rd;
    logic         valid, busy, err;

    logic [31:0]  a1 = '0;
    logic         r1 = 1'b0;
    logic         w1 = 1'b0;
    logic [255:0] wd1 = '0;
    logic [255:0] rd1;
    logic         v1, b1, e1;

    always #5 clk = ~clk;

    mm_model #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mm_a(a), .mm_read(rd_req), .mm_write(wr_req),
        .mm_wd(wd), .mm_rd(rd), .mm_valid(valid), .mm_busy(busy), .mm_err(err)
    );

    mm_model #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mm_a(a1), .mm_read(r1), .mm_write(w1),
        .mm_wd(wd1), .mm_rd(rd1), .mm_valid(v1), .mm_busy(b1), .mm_err(e1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Transaction-level model: each accepted request owns cycles (accept, free_at).
    int           cyc = 0;
    int           free_at = 0;
    int           valid_at = -1;
    bit           pend = 1'b0;
    int           pend_at = 0;
    int           pend_idx = 0;
    logic [255:0] pend_d = '0;
    logic [255:0] exp_rd = '0;
    logic         exp_err = 1'b0;
    logic [255:0] mem_m [0:1023];
    bit           run_cmp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            free_at  <= 0;
            valid_at <= -1;
            pend     <= 1'b0;
            exp_rd   <= '0;
            exp_err  <= 1'b0;
        end else begin
            if (pend && cyc == pend_at) begin
                mem_m[pend_idx] <= pend_d;
                pend            <= 1'b0;
            end
            if (cyc >= free_at) begin
                if (wr_req) begin
                    pend     <= 1'b1;
                    pend_at  <= cyc + LAT;
                    pend_idx <= int'(a[14:5]);
                    pend_d   <= wd;
                    free_at  <= cyc + LAT + 1;
                    if (rd_req && CHK) exp_err <= 1'b1;
                end else if (rd_req) begin
                    exp_rd   <= mem_m[a[14:5]];
                    valid_at <= cyc + LAT;
                    free_at  <= cyc + LAT + 1;
                end
            end else if ((rd_req || wr_req) && CHK) begin
                exp_err <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && run_cmp) begin
            chk("busy", {255'd0, busy}, {255'd0, cyc < free_at});
            chk("valid", {255'd0, valid}, {255'd0, cyc == valid_at});
            chk("err", {255'd0, err}, {255'd0, exp_err});
            if (cyc == valid_at) chk("rd", rd, exp_rd);
        end
    end

    task automatic req(input logic r, input logic w, input logic [31:0] addr, input logic [255:0] d);
        @(negedge clk);
        rd_req = r; wr_req = w; a = addr; wd = d;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", {255'd0, busy}, 256'd0);
    endtask

    task automatic rd_probe(input logic [31:0] addr, input int extra_k,
                            output int lat, output int bc, output int vc, output logic [255:0] data);
        lat = -1; bc = 0; vc = 0; data = '0;
        @(negedge clk);
        a = addr; rd_req = 1'b1;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            if (k == 1) rd_req = 1'b0;
            if (k == extra_k) rd_req = 1'b1;
            if (k == extra_k + 1) rd_req = 1'b0;
            if (valid) begin
                vc++;
                if (lat < 0) lat = k;
                data = rd;
            end
            if (busy) bc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, vc;
        logic [255:0] data;
        logic [255:0] a5, pat, col;
        a5  = {32{8'hA5}};
        pat = {8{32'h12345678}};
        col = {8{32'hC011_1DE5}};

        repeat (3) @(negedge clk);
        chk("reset_busy", {255'd0, busy}, 256'd0);
        chk("reset_valid", {255'd0, valid}, 256'd0);
        chk("reset_rd", rd, 256'd0);
        chk("reset_err", {255'd0, err}, 256'd0);
        reset = 1'b0;
        run_cmp = 1'b1;

        req(1'b0, 1'b1, 32'h0000_0200, a5);
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            req(1'b0, 1'b1, 32'(i) << 5, rnd_line());
            wait_idle();
        end

        // Basic read of line 0x010.
        rd_probe(32'h0000_0200, 0, lat, bc, vc, data);
        chk("t1_latency", 256'(lat), 256'd4);
        chk("t1_busy_cycles", 256'(bc), 256'd4);
        chk("t1_valid_count", 256'(vc), 256'd1);
        chk("t1_data", data, a5);

        // Write then read at the first legal edge.
        req(1'b0, 1'b1, 32'h0000_0400, pat);
        repeat (LAT - 1) @(negedge clk);
        rd_probe(32'h0000_0400, 0, lat, bc, vc, data);
        chk("t2_latency", 256'(lat), 256'd4);
        chk("t2_data", data, pat);
        chk("t2_err_clean", {255'd0, err}, 256'd0);

        // Read presented while busy is dropped.
        rd_probe(32'h0000_0200, 2, lat, bc, vc, data);
        chk("t3_valid_count", 256'(vc), 256'd1);
        chk("t3_data", data, a5);
        chk("t3_err", {255'd0, err}, {255'd0, CHK});
        repeat (3) @(negedge clk);
        chk("t3_err_sticky", {255'd0, err}, {255'd0, CHK});

        // Collision in IDLE: write wins.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("t4_err_cleared", {255'd0, err}, 256'd0);
        @(negedge clk);
        a = 32'h0000_0080; wd = col; rd_req = 1'b1; wr_req = 1'b1;
        vc = 0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin rd_req = 1'b0; wr_req = 1'b0; end
            if (valid) vc++;
        end
        chk("t4_no_valid", 256'(vc), 256'd0);
        chk("t4_err", {255'd0, err}, {255'd0, CHK});
        wait_idle();
        rd_probe(32'h0000_0080, 0, lat, bc, vc, data);
        chk("t4_data", data, col);

        // Reset two cycles into a write drops it.
        @(negedge clk);
        a = 32'h0000_0200; wd = ~a5; wr_req = 1'b1;
        @(negedge clk); wr_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
        chk("t5_busy", {255'd0, busy}, 256'd0);
        chk("t5_valid", {255'd0, valid}, 256'd0);
        chk("t5_rd", rd, 256'd0);
        chk("t5_err", {255'd0, err}, 256'd0);
        @(negedge clk); reset = 1'b0;
        rd_probe(32'h0000_0200, 0, lat, bc, vc, data);
        chk("t5_data_kept", data, a5);

        // Upper address bits alias onto the same line.
        rd_probe(32'h0000_8200, 0, lat, bc, vc, data);
        chk("t6_alias", data, a5);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            a      = ($urandom & ~32'h0000_7FE0) | (32'($urandom_range(0, 7)) << 5);
            wd     = rnd_line();
            rd_req = ($urandom_range(0, 2) == 0);
            wr_req = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        // LATENCY=1 instance: one-cycle latency, back-to-back every two cycles.
        @(negedge clk); a1 = 32'h0000_0200; wd1 = {32{8'h5A}}; w1 = 1'b1;
        @(negedge clk); w1 = 1'b0;
        @(negedge clk); a1 = 32'h0000_8200; r1 = 1'b1;
        lat = -1; vc = 0; data = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (v1) begin
                vc++;
                if (lat < 0) lat = k;
                data = rd1;
            end
        end
        r1 = 1'b0;
        chk("l1_latency", 256'(lat), 256'd1);
        chk("l1_valid_count", 256'(vc), 256'd4);
        chk("l1_data", data, {32{8'h5A}});

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
